// File: rtl/timer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : timer_sequencer
// Brief    : Programs an interval-timer slave, services its timeouts and halts it.
// Revision : 1.0 - initial release
// ============================================================================
module timer_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_period,
    input  logic             cmd_continuous,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             abort,
    output logic [2:0]       tmr_address,
    output logic             tmr_chipselect,
    output logic             tmr_write_n,
    output logic [15:0]      tmr_writedata,
    input  logic             tmr_irq,
    output logic             busy,
    output logic             tick,
    output logic [CNT_W-1:0] tick_count,
    output logic             done,
    output logic             aborted,
    output logic             error
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_WR_STOP  = 4'd1;
    localparam logic [3:0] S_WR_PL    = 4'd2;
    localparam logic [3:0] S_WR_PH    = 4'd3;
    localparam logic [3:0] S_WR_CTRL  = 4'd4;
    localparam logic [3:0] S_WAIT_IRQ = 4'd5;
    localparam logic [3:0] S_CLR      = 4'd6;
    localparam logic [3:0] S_RESTART  = 4'd7;
    localparam logic [3:0] S_WR_HALT  = 4'd8;
    localparam logic [3:0] S_FIN      = 4'd9;

    localparam logic [15:0] c_CTRL_STOP  = 16'h0008;
    localparam logic [15:0] c_CTRL_START = 16'h0005;

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [31:0]      r_period;
    logic             r_continuous;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_tick_count;
    logic             r_done;
    logic             r_aborted;
    logic             r_error;
    logic             w_accept;
    logic             w_abort_ok;
    logic             w_last_tick;
    logic [CNT_W-1:0] w_tick_inc;

    assign w_accept    = cmd_valid && (r_state == S_IDLE);
    assign w_abort_ok  = abort && (r_state != S_IDLE) && (r_state != S_WR_HALT)
                         && (r_state != S_FIN);
    assign w_tick_inc  = r_tick_count + CNT_W'(1);
    assign w_last_tick = (r_count != '0) && (w_tick_inc == r_count);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (cmd_valid) w_next = (cmd_period == 32'd0) ? S_FIN : S_WR_STOP;
            S_WR_STOP:  w_next = S_WR_PL;
            S_WR_PL:    w_next = S_WR_PH;
            S_WR_PH:    w_next = S_WR_CTRL;
            S_WR_CTRL:  w_next = S_WAIT_IRQ;
            S_WAIT_IRQ: if (tmr_irq) w_next = S_CLR;
            // irq is deliberately not looked at here: the flag is being cleared this cycle
            S_CLR: begin
                if (w_last_tick)        w_next = S_WR_HALT;
                else if (!r_continuous) w_next = S_RESTART;
                else                    w_next = S_WAIT_IRQ;
            end
            S_RESTART:  w_next = S_WAIT_IRQ;
            S_WR_HALT:  w_next = S_FIN;
            S_FIN:      w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
        if (w_abort_ok) w_next = S_WR_HALT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_period     <= '0;
            r_continuous <= 1'b0;
            r_count      <= '0;
            r_tick_count <= '0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIN);
            if (w_accept) begin
                r_period     <= cmd_period;
                r_continuous <= cmd_continuous;
                r_count      <= cmd_count;
                r_tick_count <= '0;
                r_aborted    <= 1'b0;
                r_error      <= 1'b0;
            end else begin
                if (r_state == S_CLR) r_tick_count <= w_tick_inc;
                if (w_abort_ok) r_aborted <= 1'b1;
                // Zero period is only seen in FIN when every write was skipped
                if ((r_state == S_FIN) && (r_period == 32'd0)) r_error <= 1'b1;
            end
        end
    end

    always_comb begin
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_address    = 3'd0;
        tmr_writedata  = 16'h0000;
        case (r_state)
            S_WR_STOP: begin
                tmr_chipselect = 1'b1;
                tmr_address    = 3'd1;
                tmr_writedata  = c_CTRL_STOP;
            end
            S_WR_PL: begin
                tmr_chipselect = 1'b1;
                tmr_address    = 3'd2;
                tmr_writedata  = r_period[15:0];
            end
            S_WR_PH: begin
                tmr_chipselect = 1'b1;
                tmr_address    = 3'd3;
                tmr_writedata  = r_period[31:16];
            end
            S_WR_CTRL: begin
                tmr_chipselect = 1'b1;
                tmr_address    = 3'd1;
                tmr_writedata  = c_CTRL_START | {14'd0, r_continuous, 1'b0};
            end
            S_CLR: begin
                tmr_chipselect = 1'b1;
                tmr_address    = 3'd0;
                tmr_writedata  = 16'h0000;
            end
            S_RESTART: begin
                tmr_chipselect = 1'b1;
                tmr_address    = 3'd1;
                tmr_writedata  = c_CTRL_START;
            end
            S_WR_HALT: begin
                tmr_chipselect = 1'b1;
                tmr_address    = 3'd1;
                tmr_writedata  = c_CTRL_STOP;
            end
            default: ;
        endcase
        if (tmr_chipselect) tmr_write_n = 1'b0;
    end

    assign cmd_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign tick       = (r_state == S_CLR);
    assign tick_count = r_tick_count;
    assign done       = r_done;
    assign aborted    = r_aborted;
    assign error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_timer_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_timer_sequencer
// Brief    : Scoreboard bench: expected bus writes and done results are queued
//            by the stimulus and consumed by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_sequencer;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_period;
    logic             cmd_continuous;
    logic [CNT_W-1:0] cmd_count;
    logic             abort;
    logic [2:0]       tmr_address;
    logic             tmr_chipselect;
    logic             tmr_write_n;
    logic [15:0]      tmr_writedata;
    logic             tmr_irq;
    logic             busy;
    logic             tick;
    logic [CNT_W-1:0] tick_count;
    logic             done;
    logic             aborted;
    logic             error;

    timer_sequencer #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_period     (cmd_period),
        .cmd_continuous (cmd_continuous),
        .cmd_count      (cmd_count),
        .abort          (abort),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_irq        (tmr_irq),
        .busy           (busy),
        .tick           (tick),
        .tick_count     (tick_count),
        .done           (done),
        .aborted        (aborted),
        .error          (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct packed {
        logic [CNT_W-1:0] ticks;
        logic             abrt;
        logic             err;
    } done_t;

    wr_t   exp_wr[$];
    done_t exp_done[$];
    wr_t   m_wr;
    done_t m_done;
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: consumes expectations whenever the DUT shows a write or done
    always @(negedge clk) begin
        if (!reset) begin
            check("ready_vs_busy", {31'd0, cmd_ready}, {31'd0, ~busy});
            check("write_n_vs_cs", {31'd0, tmr_write_n}, {31'd0, ~tmr_chipselect});
            if (tick || tmr_chipselect)
                check("tick_with_clr", {31'd0, tick},
                      {31'd0, tmr_chipselect && (tmr_address == 3'd0)});
            if (!tmr_chipselect)
                check("idle_bus", {13'd0, tmr_address, tmr_writedata}, 32'd0);
            if (tmr_chipselect) begin
                if (exp_wr.size() == 0) begin
                    fail_event($sformatf("unexpected_write addr=%0d data=0x%04h",
                                         tmr_address, tmr_writedata));
                end else begin
                    m_wr = exp_wr.pop_front();
                    check("wr_addr", {29'd0, tmr_address}, {29'd0, m_wr.addr});
                    check("wr_data", {16'd0, tmr_writedata}, {16'd0, m_wr.data});
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    fail_event("unexpected_done");
                end else begin
                    m_done = exp_done.pop_front();
                    check("done_tick_count", {24'd0, tick_count}, {24'd0, m_done.ticks});
                    check("done_aborted", {31'd0, aborted}, {31'd0, m_done.abrt});
                    check("done_error", {31'd0, error}, {31'd0, m_done.err});
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [2:0] a, input logic [15:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_wr.push_back(w);
    endtask

    task automatic push_done(input logic [CNT_W-1:0] t, input logic a, input logic e);
        done_t d;
        d.ticks = t;
        d.abrt  = a;
        d.err   = e;
        exp_done.push_back(d);
    endtask

    task automatic push_setup(input logic [31:0] p, input logic cont);
        push_wr(3'd1, 16'h0008);
        push_wr(3'd2, p[15:0]);
        push_wr(3'd3, p[31:16]);
        push_wr(3'd1, cont ? 16'h0007 : 16'h0005);
    endtask

    // Returns one cycle after the accepting edge (DUT then in its first post-accept state)
    task automatic issue(input logic [31:0] p, input logic cont, input logic [CNT_W-1:0] cnt);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 200) begin
            step(1);
            guard++;
        end
        if (!cmd_ready) fail_event("cmd_ready_timeout");
        cmd_valid      = 1'b1;
        cmd_period     = p;
        cmd_continuous = cont;
        cmd_count      = cnt;
        step(1);
        cmd_valid = 1'b0;
    endtask

    task automatic pulse_irq();
        tmr_irq = 1'b1;
        step(1);
        tmr_irq = 1'b0;
        step(3);
    endtask

    task automatic wait_done(input string name);
        int guard;
        guard = 0;
        while (exp_done.size() != 0 && guard < 100) begin
            step(1);
            guard++;
        end
        check({name, "_done_seen"}, exp_done.size(), 0);
        check({name, "_writes_drained"}, exp_wr.size(), 0);
        step(2);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_tick_done"}, {30'd0, tick, done}, 32'd0);
        check({name, "_flags"}, {30'd0, aborted, error}, 32'd0);
        check({name, "_tick_count"}, {24'd0, tick_count}, 32'd0);
        check({name, "_cs_wn"}, {30'd0, tmr_chipselect, tmr_write_n}, 32'd1);
        check({name, "_addr_data"}, {13'd0, tmr_address, tmr_writedata}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        reset          = 1'b1;
        cmd_valid      = 1'b0;
        cmd_period     = 32'd0;
        cmd_continuous = 1'b0;
        cmd_count      = '0;
        abort          = 1'b0;
        tmr_irq        = 1'b0;
        step(3);
        check_reset_values("reset");
        reset = 1'b0;
        step(2);

        // Continuous, three timeouts then self-halt
        push_setup(32'h0002_FAF0, 1'b1);
        issue(32'h0002_FAF0, 1'b1, 8'd3);
        step(4);
        for (int i = 0; i < 3; i++) begin
            push_wr(3'd0, 16'h0000);
            if (i == 2) begin
                push_wr(3'd1, 16'h0008);
                push_done(8'd3, 1'b0, 1'b0);
            end
            pulse_irq();
        end
        wait_done("continuous");

        // One-shot: the non-final clear is followed by a restart write
        push_setup(32'h0000_1234, 1'b0);
        issue(32'h0000_1234, 1'b0, 8'd2);
        step(4);
        push_wr(3'd0, 16'h0000);
        push_wr(3'd1, 16'h0005);
        pulse_irq();
        push_wr(3'd0, 16'h0000);
        push_wr(3'd1, 16'h0008);
        push_done(8'd2, 1'b0, 1'b0);
        pulse_irq();
        wait_done("oneshot");

        // Unbounded run ended by abort after five timeouts
        push_setup(32'h0001_0000, 1'b1);
        issue(32'h0001_0000, 1'b1, 8'd0);
        step(4);
        for (int i = 0; i < 5; i++) begin
            push_wr(3'd0, 16'h0000);
            pulse_irq();
        end
        check("unbounded_ticks", {24'd0, tick_count}, 32'd5);
        push_wr(3'd1, 16'h0008);
        push_done(8'd5, 1'b1, 1'b0);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        wait_done("abort_run");

        // Zero period: no bus writes, done with error two cycles after acceptance
        push_done(8'd0, 1'b0, 1'b1);
        issue(32'd0, 1'b1, 8'd4);
        check("zero_period_cycle1_done", {31'd0, done}, 32'd0);
        step(1);
        check("zero_period_cycle2_done_err", {30'd0, done, error}, 32'd3);
        wait_done("zero_period");

        // Abort and irq together in WAIT_IRQ: abort wins, no clear write
        push_setup(32'h0000_0100, 1'b1);
        issue(32'h0000_0100, 1'b1, 8'd0);
        step(4);
        push_wr(3'd1, 16'h0008);
        push_done(8'd0, 1'b1, 1'b0);
        tmr_irq = 1'b1;
        abort   = 1'b1;
        step(1);
        tmr_irq = 1'b0;
        abort   = 1'b0;
        wait_done("abort_irq");

        // Reset in WR_PH: outputs return at once, nothing further on the bus
        push_wr(3'd1, 16'h0008);
        push_wr(3'd2, 16'hCDEF);
        issue(32'h00AB_CDEF, 1'b0, 8'd1);
        step(2);
        reset = 1'b1;
        #1;
        check_reset_values("midrun_reset");
        step(2);
        reset = 1'b0;
        step(1);
        check("post_reset_ready", {31'd0, cmd_ready}, 32'd1);
        step(8);
        check("post_reset_writes_drained", exp_wr.size(), 0);
        check("post_reset_no_done", exp_done.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
